// File: rtl/add32_sequencer.sv
// 32-bit add/subtract done in two 16-bit passes through one shared carry-select adder,
// with a valid/ready handshake on both sides.

module carry_select_add16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        carry_out
);
    logic [8:0] lo_full;
    logic [8:0] hi_c0;
    logic [8:0] hi_c1;

    // Upper byte is precomputed for both possible carries; the lower carry picks one.
    always_comb begin
        lo_full = {1'b0, x[7:0]} + {1'b0, y[7:0]} + {8'd0, carry_in};
        hi_c0   = {1'b0, x[15:8]} + {1'b0, y[15:8]};
        hi_c1   = {1'b0, x[15:8]} + {1'b0, y[15:8]} + 9'd1;
        sum[7:0] = lo_full[7:0];
        if (lo_full[8]) begin
            sum[15:8] = hi_c1[7:0];
            carry_out = hi_c1[8];
        end else begin
            sum[15:8] = hi_c0[7:0];
            carry_out = hi_c0[8];
        end
    end
endmodule

// state | meaning
// IDLE  | in_ready high, waiting for an operation
// LOW   | adding the low halves, carry_in = sub
// HIGH  | adding the high halves, carry_in = low-half carry
// DONE  | result presented, waiting for out_ready
module add32_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        carry_out,
    output logic        overflow
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sub_q;
    logic        carry_q;

    logic [15:0] add_x;
    logic [15:0] add_y;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;

    assign in_ready = (state == ST_IDLE);

    always_comb begin
        if (state == ST_HIGH) begin
            add_x   = a_q[31:16];
            add_y   = b_q[31:16];
            add_cin = carry_q;
        end else begin
            add_x   = a_q[15:0];
            add_y   = b_q[15:0];
            add_cin = sub_q;
        end
    end

    carry_select_add16 u_add (
        .x         (add_x),
        .y         (add_y),
        .carry_in  (add_cin),
        .sum       (add_sum),
        .carry_out (add_cout)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
            result    <= 32'd0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        sub_q <= sub;
                        state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    result[15:0] <= add_sum;
                    carry_q      <= add_cout;
                    state        <= ST_HIGH;
                end
                ST_HIGH: begin
                    result[31:16] <= add_sum;
                    carry_out     <= add_cout;
                    overflow      <= (a_q[31] == b_q[31]) & (add_sum[15] != a_q[31]);
                    out_valid     <= 1'b1;
                    state         <= ST_DONE;
                end
                default: begin
                    // A request arriving with out_ready is left for the next IDLE cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
